// File: rtl/lbist_pkg.sv
// Shared types and defaults for the LBIST session controller and its MISR.
package lbist_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_RUN     = 3'd2,
        S_DRAIN   = 3'd3,
        S_COMPARE = 3'd4,
        S_DONE    = 3'd5
    } lbist_state_e;

    localparam logic [15:0] DEFAULT_MISR_POLY = 16'h1021;

endpackage

// File: rtl/lbist_misr.sv
// Multiple-input signature register: shift-left with polynomial feedback, response
// XORed into the low bits. A load takes priority over a capture.
module lbist_misr
    import lbist_pkg::*;
#(
    parameter int                  SIG_BITS  = 16,
    parameter int                  RESP_BITS = 4,
    parameter logic [SIG_BITS-1:0] MISR_POLY = SIG_BITS'(DEFAULT_MISR_POLY),
    parameter logic [SIG_BITS-1:0] RST_VAL   = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [SIG_BITS-1:0]  seed,
    input  logic                 en,
    input  logic [RESP_BITS-1:0] resp,
    output logic [SIG_BITS-1:0]  sig
);

    logic [SIG_BITS-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = seed;
        end else if (en) begin
            sig_d = (sig_q << 1)
                  ^ (sig_q[SIG_BITS-1] ? MISR_POLY : '0)
                  ^ SIG_BITS'(resp);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sig_q <= RST_VAL;
        else          sig_q <= sig_d;
    end

    assign sig = sig_q;

endmodule

// File: rtl/lbist_ctrl.sv
// LBIST session sequencer: seeds the pattern generator, steps it PATTERN_COUNT times,
// compacts the delayed CUT responses in a MISR and compares against a golden signature.
module lbist_ctrl
    import lbist_pkg::*;
#(
    parameter int                  INPUT_BITS    = 4,
    parameter int                  RESP_BITS     = 4,
    parameter int                  SIG_BITS      = 16,
    parameter int                  PATTERN_COUNT = 15,
    parameter int                  CUT_LATENCY   = 1,
    parameter logic [SIG_BITS-1:0] MISR_POLY     = SIG_BITS'(DEFAULT_MISR_POLY),
    parameter logic [SIG_BITS-1:0] MISR_SEED     = '0,
    parameter logic [SIG_BITS-1:0] GOLDEN_SIG    = '0,
    localparam int                 CNT_W         = $clog2(PATTERN_COUNT + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    output logic                 tpg_init,
    output logic                 tpg_step,
    input  logic [RESP_BITS-1:0] cut_resp,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [SIG_BITS-1:0]  signature,
    output logic [CNT_W-1:0]     pattern_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(PATTERN_COUNT);
    localparam logic [2:0]       DRAIN_LAST = (CUT_LATENCY == 0) ? 3'd0 : 3'(CUT_LATENCY - 1);

    lbist_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       drain_q, drain_d;
    logic             pass_q, pass_d;
    logic             cap_en;
    logic             pipe_clr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                end
            end
            S_INIT: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_MAX - CNT_W'(1)) begin
                    state_d = (CUT_LATENCY == 0) ? S_COMPARE : S_DRAIN;
                    drain_d = '0;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) state_d = S_COMPARE;
                else                       drain_d = drain_q + 3'd1;
            end
            S_COMPARE: state_d = S_DONE;
            S_DONE: begin
                if (start) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides everything, including a simultaneous start; the count is frozen.
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = cnt_q;
        end
    end

    always_comb begin
        pass_d = 1'b0;
        if (state_d == S_DONE) pass_d = (state_q == S_COMPARE) ? (signature == GOLDEN_SIG) : pass_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            drain_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            pass_q  <= pass_d;
        end
    end

    assign tpg_init    = (state_q == S_INIT);
    assign tpg_step    = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign busy        = (state_q == S_INIT) || (state_q == S_RUN) ||
                         (state_q == S_DRAIN) || (state_q == S_COMPARE);
    assign pass        = pass_q;
    assign pattern_cnt = cnt_q;
    assign pipe_clr    = abort || (state_q == S_INIT);

    // Delay line marking which cycles carry a valid response for a step issued earlier.
    if (CUT_LATENCY == 0) begin : g_no_lat
        assign cap_en = tpg_step;
    end else begin : g_lat
        logic [CUT_LATENCY-1:0] pipe_q, pipe_d;

        always_comb begin
            pipe_d = (pipe_q << 1) | CUT_LATENCY'(tpg_step);
            if (pipe_clr) pipe_d = '0;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) pipe_q <= '0;
            else          pipe_q <= pipe_d;
        end

        assign cap_en = pipe_q[CUT_LATENCY-1];
    end

    lbist_misr #(
        .SIG_BITS  (SIG_BITS),
        .RESP_BITS (RESP_BITS),
        .MISR_POLY (MISR_POLY),
        .RST_VAL   (MISR_SEED)
    ) u_misr (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (tpg_init && !abort),
        .seed    (MISR_SEED),
        .en      (cap_en && !abort),
        .resp    (cut_resp),
        .sig     (signature)
    );

endmodule

// File: tb/tb_lbist_ctrl.sv
// Directed bench for lbist_ctrl: four instances share one stimulus and differ in
// golden signature, MISR width and CUT latency.
module tb_lbist_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic [0:0] cut_resp;

    // Main instance: 4-bit MISR, poly 3, latency 1, golden F
    logic       init_f, step_f, busy_f, done_f, pass_f;
    logic [3:0] sig_f;
    logic [2:0] cnt_f;
    // Same but golden E
    logic       init_e, step_e, busy_e, done_e, pass_e;
    logic [3:0] sig_e;
    logic [2:0] cnt_e;
    // Same but golden 0
    logic       init_z, step_z, busy_z, done_z, pass_z;
    logic [3:0] sig_z;
    logic [2:0] cnt_z;
    // 2-bit MISR, poly 3, latency 0, golden 1
    logic       init_l, step_l, busy_l, done_l, pass_l;
    logic [1:0] sig_l;
    logic [2:0] cnt_l;

    int n_cmp = 0;
    int n_bad = 0;
    int td, ns, ni, td_l;

    always #5 clk = ~clk;

    lbist_ctrl #(.INPUT_BITS(4), .RESP_BITS(1), .SIG_BITS(4), .PATTERN_COUNT(4), .CUT_LATENCY(1),
                 .MISR_POLY(4'h3), .MISR_SEED(4'h0), .GOLDEN_SIG(4'hF)) u_dut_f (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .tpg_init(init_f),
        .tpg_step(step_f), .cut_resp(cut_resp), .busy(busy_f), .done(done_f), .pass(pass_f),
        .signature(sig_f), .pattern_cnt(cnt_f));

    lbist_ctrl #(.INPUT_BITS(4), .RESP_BITS(1), .SIG_BITS(4), .PATTERN_COUNT(4), .CUT_LATENCY(1),
                 .MISR_POLY(4'h3), .MISR_SEED(4'h0), .GOLDEN_SIG(4'hE)) u_dut_e (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .tpg_init(init_e),
        .tpg_step(step_e), .cut_resp(cut_resp), .busy(busy_e), .done(done_e), .pass(pass_e),
        .signature(sig_e), .pattern_cnt(cnt_e));

    lbist_ctrl #(.INPUT_BITS(4), .RESP_BITS(1), .SIG_BITS(4), .PATTERN_COUNT(4), .CUT_LATENCY(1),
                 .MISR_POLY(4'h3), .MISR_SEED(4'h0), .GOLDEN_SIG(4'h0)) u_dut_z (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .tpg_init(init_z),
        .tpg_step(step_z), .cut_resp(cut_resp), .busy(busy_z), .done(done_z), .pass(pass_z),
        .signature(sig_z), .pattern_cnt(cnt_z));

    lbist_ctrl #(.INPUT_BITS(4), .RESP_BITS(1), .SIG_BITS(2), .PATTERN_COUNT(4), .CUT_LATENCY(0),
                 .MISR_POLY(2'h3), .MISR_SEED(2'h0), .GOLDEN_SIG(2'h1)) u_dut_l0 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .tpg_init(init_l),
        .tpg_step(step_l), .cut_resp(cut_resp), .busy(busy_l), .done(done_l), .pass(pass_l),
        .signature(sig_l), .pattern_cnt(cnt_l));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then count edges until done on the latency-1 and latency-0 instances.
    task automatic run_session(input int mid_start, output int t_done, output int n_step,
                               output int n_init, output int t_done_l);
        start    = 1'b1;
        t_done   = 0;
        n_step   = 0;
        n_init   = 0;
        t_done_l = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            start = (n == mid_start);
            if (step_f) n_step++;
            if (init_f) n_init++;
            if (done_f && t_done == 0)   t_done = n;
            if (done_l && t_done_l == 0) t_done_l = n;
            if (t_done != 0 && t_done_l != 0) break;
        end
    endtask

    task automatic wait_done(output int t_done);
        t_done = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (done_f) begin
                t_done = n;
                break;
            end
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        cut_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", busy_f, 0);
        check_eq("rst_done", done_f, 0);
        check_eq("rst_pass", pass_f, 0);
        check_eq("rst_init", init_f, 0);
        check_eq("rst_step", step_f, 0);
        check_eq("rst_sig",  sig_f, 4'h0);
        check_eq("rst_cnt",  cnt_f, 0);
        reset_n = 1'b1;
        tick();

        // Zero responses: signature stays at seed
        cut_resp = 1'b0;
        run_session(0, td, ns, ni, td_l);
        check_eq("t1_latency", td, 8);
        check_eq("t1_steps",   ns, 4);
        check_eq("t1_inits",   ni, 1);
        check_eq("t1_sig",     sig_f, 4'h0);
        check_eq("t1_cnt",     cnt_f, 4);
        check_eq("t1_pass_z",  pass_z, 1);
        check_eq("t1_pass_f",  pass_f, 0);
        check_eq("t1_pass_e",  pass_e, 0);
        check_eq("t1_lat0",    td_l, 7);
        check_eq("t1_sig_l0",  sig_l, 2'h0);
        check_eq("t1_pass_l0", pass_l, 0);
        tick();
        tick();
        check_eq("t1_done_hold", done_f, 1);
        check_eq("t1_pass_hold", pass_z, 1);
        check_eq("t1_busy_idle", busy_f, 0);

        // Constant 1: MISR 1,3,7,F; extra start during RUN must be ignored
        cut_resp = 1'b1;
        run_session(3, td, ns, ni, td_l);
        check_eq("t2_latency", td, 8);
        check_eq("t2_steps",   ns, 4);
        check_eq("t2_inits",   ni, 1);
        check_eq("t2_sig_f",   sig_f, 4'hF);
        check_eq("t2_pass_f",  pass_f, 1);
        check_eq("t3_sig_e",   sig_e, 4'hF);
        check_eq("t3_pass_e",  pass_e, 0);
        check_eq("t3_done_e",  done_e, 1);
        check_eq("t2_pass_z",  pass_z, 0);
        check_eq("t2_lat0",    td_l, 7);
        check_eq("t2_sig_l0",  sig_l, 2'h1);
        check_eq("t2_pass_l0", pass_l, 1);

        // Start while in DONE restarts the session
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t5_init",  init_f, 1);
        check_eq("t5_busy",  busy_f, 1);
        check_eq("t5_done",  done_f, 0);
        check_eq("t5_pass",  pass_f, 0);
        check_eq("t5_cnt",   cnt_f, 0);
        wait_done(td);
        check_eq("t5_latency", td, 7);
        check_eq("t5_sig",     sig_f, 4'hF);
        check_eq("t5_pass_end", pass_f, 1);

        // Abort in the second RUN cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_eq("t4_in_run", step_f, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("t4_busy", busy_f, 0);
        check_eq("t4_done", done_f, 0);
        check_eq("t4_step", step_f, 0);
        check_eq("t4_pass", pass_f, 0);
        check_eq("t4_sig_hold", sig_f, 4'h0);
        check_eq("t4_cnt_hold", cnt_f, 1);
        ns = 0;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (step_f) ns++;
        end
        check_eq("t4_no_steps", ns, 0);

        // Start and abort together: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_eq("sa_busy", busy_f, 0);
        check_eq("sa_init", init_f, 0);

        // Asynchronous reset while in DRAIN
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check_eq("t6_drain_busy", busy_f, 1);
        check_eq("t6_drain_step", step_f, 0);
        check_eq("t6_drain_sig",  sig_f, 4'h7);
        check_eq("t6_drain_cnt",  cnt_f, 4);
        reset_n = 1'b0;
        #1;
        check_eq("t6_rst_busy", busy_f, 0);
        check_eq("t6_rst_done", done_f, 0);
        check_eq("t6_rst_pass", pass_f, 0);
        check_eq("t6_rst_sig",  sig_f, 4'h0);
        check_eq("t6_rst_cnt",  cnt_f, 0);
        tick();
        reset_n = 1'b1;
        tick();
        run_session(0, td, ns, ni, td_l);
        check_eq("t6_latency", td, 8);
        check_eq("t6_steps",   ns, 4);
        check_eq("t6_sig",     sig_f, 4'hF);
        check_eq("t6_pass",    pass_f, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
